// File: rtl/pa_core_trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pa_core_trap_ctrl_pkg
// Shared constants for the machine-mode trap controller:
//   - machine CSR addresses
//   - mstatus bit positions (MIE, MPIE, MPP)
//   - interrupt cause codes
//   - trap FSM state encoding (3 bit)
// ---------------------------------------------------------------------------
package pa_core_trap_ctrl_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // mstatus bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Interrupt cause values (bit 31 marks an interrupt)
  localparam logic [31:0] CAUSE_M_EXT = 32'h8000_000B;
  localparam logic [31:0] CAUSE_M_TMR = 32'h8000_0007;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_MEPC    = 3'd1,
    ST_WR_MCAUSE  = 3'd2,
    ST_WR_MTVAL   = 3'd3,
    ST_WR_MSTATUS = 3'd4,
    ST_MRET       = 3'd5,
    ST_JUMP       = 3'd6
  } trap_state_e;

endpackage

// File: rtl/pa_core_trap_ctrl.sv
// ---------------------------------------------------------------------------
// pa_core_trap_ctrl
// Sequences the machine-mode CSR file on trap entry (exception / interrupt)
// and MRET, and arbitrates the single CSR write port between the EX-stage
// CSR instruction and its own trap sequence.
//
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   exc_vld_i/cause/tval      synchronous exception from EX
//   ex_pc_i                   PC of the instruction in EX
//   irq_ext_i, irq_tmr_i      level interrupts (external beats timer)
//   mret_i                    MRET in EX
//   inst_csr_we/waddr/wdata   CSR instruction write request
//   csr_mtvec/mepc/mstatus_i  current CSR file values
//   csr_waddr/_vld/wdata_o    CSR file write port
//   hold_o                    pipeline stall / fetch suppress
//   jump_o, jump_addr_o       one-cycle redirect strobe and target
//
// State | meaning
//   IDLE       | accept exception > interrupt > MRET > CSR instruction write
//   WR_MEPC    | write mepc  <- epc & ~3
//   WR_MCAUSE  | write mcause <- latched cause
//   WR_MTVAL   | write mtval <- latched tval
//   WR_MSTATUS | write mstatus with trap-entry stacking of MIE
//   MRET       | write mstatus with MRET unstacking of MPIE
//   JUMP       | redirect strobe to mtvec (trap) or mepc (MRET)
// ---------------------------------------------------------------------------
module pa_core_trap_ctrl
  import pa_core_trap_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              exc_vld_i,
  input  logic [3:0]        exc_cause_i,
  input  logic [DATA_W-1:0] exc_tval_i,
  input  logic [DATA_W-1:0] ex_pc_i,
  input  logic              irq_ext_i,
  input  logic              irq_tmr_i,
  input  logic              mret_i,
  input  logic              inst_csr_we_i,
  input  logic [CSR_AW-1:0] inst_csr_waddr_i,
  input  logic [DATA_W-1:0] inst_csr_wdata_i,
  input  logic [DATA_W-1:0] csr_mtvec_i,
  input  logic [DATA_W-1:0] csr_mepc_i,
  input  logic [DATA_W-1:0] csr_mstatus_i,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic              csr_waddr_vld_o,
  output logic [DATA_W-1:0] csr_wdata_o,
  output logic              hold_o,
  output logic              jump_o,
  output logic [DATA_W-1:0] jump_addr_o
);

  trap_state_e       state_q;
  logic [DATA_W-1:0] cause_q;
  logic [DATA_W-1:0] tval_q;

  // Registered outputs for the sequencing states; IDLE overlays
  // combinational hold and instruction pass-through on top of these.
  logic              csr_wvld_q;
  logic [CSR_AW-1:0] csr_waddr_q;
  logic [DATA_W-1:0] csr_wdata_q;
  logic              hold_q;
  logic              jump_q;
  logic [DATA_W-1:0] jump_addr_q;

  logic              irq_take;
  logic              trap_take;
  logic              is_idle;
  logic              inst_pass;
  logic [DATA_W-1:0] trap_cause;
  logic [DATA_W-1:0] trap_target;

  function automatic logic [DATA_W-1:0] trap_mstatus(input logic [DATA_W-1:0] ms);
    logic [DATA_W-1:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] mret_mstatus(input logic [DATA_W-1:0] ms);
    logic [DATA_W-1:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  assign irq_take  = csr_mstatus_i[MSTATUS_MIE] & (irq_ext_i | irq_tmr_i);
  assign trap_take = exc_vld_i | irq_take;

  always_comb begin
    trap_cause = DATA_W'(CAUSE_M_TMR);
    if (exc_vld_i)      trap_cause = DATA_W'(exc_cause_i);
    else if (irq_ext_i) trap_cause = DATA_W'(CAUSE_M_EXT);
  end

  // Vectored mode only applies to interrupts; offset wraps mod 2^DATA_W.
  always_comb begin
    trap_target = {csr_mtvec_i[DATA_W-1:2], 2'b00};
    if (csr_mtvec_i[1:0] == 2'b01 && cause_q[DATA_W-1])
      trap_target = trap_target + DATA_W'({cause_q[3:0], 2'b00});
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cause_q     <= '0;
      tval_q      <= '0;
      csr_wvld_q  <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      hold_q      <= 1'b0;
      jump_q      <= 1'b0;
      jump_addr_q <= '0;
    end else begin
      csr_wvld_q  <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      hold_q      <= 1'b0;
      jump_q      <= 1'b0;
      jump_addr_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (trap_take) begin
            state_q     <= ST_WR_MEPC;
            cause_q     <= trap_cause;
            tval_q      <= exc_vld_i ? exc_tval_i : '0;
            hold_q      <= 1'b1;
            csr_wvld_q  <= 1'b1;
            csr_waddr_q <= CSR_AW'(CSR_MEPC);
            csr_wdata_q <= {ex_pc_i[DATA_W-1:2], 2'b00};
          end else if (mret_i) begin
            state_q     <= ST_MRET;
            hold_q      <= 1'b1;
            csr_wvld_q  <= 1'b1;
            csr_waddr_q <= CSR_AW'(CSR_MSTATUS);
            csr_wdata_q <= mret_mstatus(csr_mstatus_i);
          end
        end
        ST_WR_MEPC: begin
          state_q     <= ST_WR_MCAUSE;
          hold_q      <= 1'b1;
          csr_wvld_q  <= 1'b1;
          csr_waddr_q <= CSR_AW'(CSR_MCAUSE);
          csr_wdata_q <= cause_q;
        end
        ST_WR_MCAUSE: begin
          state_q     <= ST_WR_MTVAL;
          hold_q      <= 1'b1;
          csr_wvld_q  <= 1'b1;
          csr_waddr_q <= CSR_AW'(CSR_MTVAL);
          csr_wdata_q <= tval_q;
        end
        ST_WR_MTVAL: begin
          // mstatus is stable while held, so sampling it a cycle early is safe
          state_q     <= ST_WR_MSTATUS;
          hold_q      <= 1'b1;
          csr_wvld_q  <= 1'b1;
          csr_waddr_q <= CSR_AW'(CSR_MSTATUS);
          csr_wdata_q <= trap_mstatus(csr_mstatus_i);
        end
        ST_WR_MSTATUS: begin
          state_q     <= ST_JUMP;
          hold_q      <= 1'b1;
          jump_q      <= 1'b1;
          jump_addr_q <= trap_target;
        end
        ST_MRET: begin
          state_q     <= ST_JUMP;
          hold_q      <= 1'b1;
          jump_q      <= 1'b1;
          jump_addr_q <= csr_mepc_i;
        end
        ST_JUMP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign is_idle   = (state_q == ST_IDLE);
  assign inst_pass = is_idle & inst_csr_we_i & ~(trap_take | mret_i);

  assign hold_o          = hold_q | (is_idle & (trap_take | mret_i));
  assign csr_waddr_vld_o = csr_wvld_q | inst_pass;
  assign csr_waddr_o     = inst_pass ? inst_csr_waddr_i : csr_waddr_q;
  assign csr_wdata_o     = inst_pass ? inst_csr_wdata_i : csr_wdata_q;
  assign jump_o          = jump_q;
  assign jump_addr_o     = jump_addr_q;

endmodule

// File: tb/tb_pa_core_trap_ctrl.sv
module tb_pa_core_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        exc_vld_i;
  logic [3:0]  exc_cause_i;
  logic [31:0] exc_tval_i;
  logic [31:0] ex_pc_i;
  logic        irq_ext_i;
  logic        irq_tmr_i;
  logic        mret_i;
  logic        inst_csr_we_i;
  logic [11:0] inst_csr_waddr_i;
  logic [31:0] inst_csr_wdata_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic [11:0] csr_waddr_o;
  logic        csr_waddr_vld_o;
  logic [31:0] csr_wdata_o;
  logic        hold_o;
  logic        jump_o;
  logic [31:0] jump_addr_o;

  int checks = 0;
  int errors = 0;

  pa_core_trap_ctrl #(.DATA_W(32), .CSR_AW(12)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .exc_vld_i        (exc_vld_i),
    .exc_cause_i      (exc_cause_i),
    .exc_tval_i       (exc_tval_i),
    .ex_pc_i          (ex_pc_i),
    .irq_ext_i        (irq_ext_i),
    .irq_tmr_i        (irq_tmr_i),
    .mret_i           (mret_i),
    .inst_csr_we_i    (inst_csr_we_i),
    .inst_csr_waddr_i (inst_csr_waddr_i),
    .inst_csr_wdata_i (inst_csr_wdata_i),
    .csr_mtvec_i      (csr_mtvec_i),
    .csr_mepc_i       (csr_mepc_i),
    .csr_mstatus_i    (csr_mstatus_i),
    .csr_waddr_o      (csr_waddr_o),
    .csr_waddr_vld_o  (csr_waddr_vld_o),
    .csr_wdata_o      (csr_wdata_o),
    .hold_o           (hold_o),
    .jump_o           (jump_o),
    .jump_addr_o      (jump_addr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Checks every output of the DUT against the expected tuple.
  task automatic chk_out(input string tag, input logic vld, input logic [11:0] addr,
                         input logic [31:0] data, input logic hold, input logic jump,
                         input logic [31:0] jaddr);
    chk({tag, ".vld"},   {31'b0, csr_waddr_vld_o}, {31'b0, vld});
    chk({tag, ".addr"},  {20'b0, csr_waddr_o},     {20'b0, addr});
    chk({tag, ".data"},  csr_wdata_o,              data);
    chk({tag, ".hold"},  {31'b0, hold_o},          {31'b0, hold});
    chk({tag, ".jump"},  {31'b0, jump_o},          {31'b0, jump});
    chk({tag, ".jaddr"}, jump_addr_o,              jaddr);
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i = 1'b0;
    exc_vld_i = 1'b0; exc_cause_i = 4'd0; exc_tval_i = '0; ex_pc_i = '0;
    irq_ext_i = 1'b0; irq_tmr_i = 1'b0; mret_i = 1'b0;
    inst_csr_we_i = 1'b0; inst_csr_waddr_i = '0; inst_csr_wdata_i = '0;
    csr_mtvec_i = '0; csr_mepc_i = '0; csr_mstatus_i = '0;

    #12;
    chk_out("reset", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n_i = 1'b1;

    // ---- instruction write passthrough ----
    tick();
    inst_csr_we_i = 1'b1; inst_csr_waddr_i = 12'h340; inst_csr_wdata_i = 32'hDEAD_BEEF;
    #1;
    chk_out("inst_wr", 1'b1, 12'h340, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    tick();
    inst_csr_we_i = 1'b0;
    #1;
    chk_out("inst_wr_idle", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);

    // ---- exception, direct mode ----
    csr_mtvec_i = 32'h0000_0800; csr_mstatus_i = 32'h0000_1888;
    exc_vld_i = 1'b1; exc_cause_i = 4'd2; ex_pc_i = 32'h100; exc_tval_i = 32'h13;
    #1;
    chk_out("exc_n", 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    exc_vld_i = 1'b0;
    chk_out("exc_mepc", 1'b1, 12'h341, 32'h100, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("exc_mcause", 1'b1, 12'h342, 32'h2, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("exc_mtval", 1'b1, 12'h343, 32'h13, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("exc_mstatus", 1'b1, 12'h300, 32'h0000_1880, 1'b1, 1'b0, 32'h0);
    csr_mstatus_i = 32'h0000_1880;
    tick();
    chk_out("exc_jump", 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 32'h800);
    tick();
    chk_out("exc_done", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);

    // ---- vectored timer interrupt with concurrent instruction write ----
    csr_mtvec_i = 32'h0000_0801; csr_mstatus_i = 32'h0000_0008;
    irq_tmr_i = 1'b1; ex_pc_i = 32'h200; exc_tval_i = 32'h55;
    inst_csr_we_i = 1'b1; inst_csr_waddr_i = 12'h340; inst_csr_wdata_i = 32'h1234_5678;
    #1;
    chk_out("tmr_n", 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    irq_tmr_i = 1'b0; inst_csr_we_i = 1'b0;
    chk_out("tmr_mepc", 1'b1, 12'h341, 32'h200, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("tmr_mcause", 1'b1, 12'h342, 32'h8000_0007, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("tmr_mtval", 1'b1, 12'h343, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("tmr_mstatus", 1'b1, 12'h300, 32'h0000_1880, 1'b1, 1'b0, 32'h0);
    csr_mstatus_i = 32'h0000_1880;
    tick();
    chk_out("tmr_jump", 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 32'h81C);
    tick();
    chk_out("tmr_done", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);

    // ---- external beats timer; misaligned PC masked in mepc ----
    csr_mstatus_i = 32'h0000_0008;
    irq_tmr_i = 1'b1; irq_ext_i = 1'b1; ex_pc_i = 32'h206;
    #1;
    chk_out("ext_n", 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    irq_tmr_i = 1'b0; irq_ext_i = 1'b0;
    chk_out("ext_mepc", 1'b1, 12'h341, 32'h204, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("ext_mcause", 1'b1, 12'h342, 32'h8000_000B, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("ext_mtval", 1'b1, 12'h343, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("ext_mstatus", 1'b1, 12'h300, 32'h0000_1880, 1'b1, 1'b0, 32'h0);
    csr_mstatus_i = 32'h0000_1880;
    tick();
    chk_out("ext_jump", 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 32'h82C);
    tick();
    chk_out("ext_done", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);

    // ---- masked interrupts do nothing ----
    irq_ext_i = 1'b1; irq_tmr_i = 1'b1;
    #1;
    chk_out("masked_n", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("masked_n1", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);

    // ---- MRET ----
    csr_mstatus_i = 32'h0000_0080; csr_mepc_i = 32'h104; mret_i = 1'b1;
    #1;
    chk_out("mret_n", 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    mret_i = 1'b0; irq_ext_i = 1'b0; irq_tmr_i = 1'b0;
    chk_out("mret_mstatus", 1'b1, 12'h300, 32'h0000_1888, 1'b1, 1'b0, 32'h0);
    csr_mstatus_i = 32'h0000_1888;
    tick();
    chk_out("mret_jump", 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 32'h104);
    tick();
    chk_out("mret_done", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);

    // ---- exception beats interrupt; reset in WR_MCAUSE ----
    csr_mtvec_i = 32'h0000_0801; csr_mstatus_i = 32'h0000_0008;
    irq_ext_i = 1'b1; exc_vld_i = 1'b1; exc_cause_i = 4'd5;
    ex_pc_i = 32'h300; exc_tval_i = 32'h44;
    #1;
    chk_out("prio_n", 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    exc_vld_i = 1'b0; irq_ext_i = 1'b0; csr_mstatus_i = 32'h0;
    chk_out("prio_mepc", 1'b1, 12'h341, 32'h300, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("prio_mcause", 1'b1, 12'h342, 32'h5, 1'b1, 1'b0, 32'h0);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_out("rst_mid", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("rst_hold", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n_i = 1'b1;

    // ---- fresh exception after reset ----
    tick();
    csr_mtvec_i = 32'h0000_0900; csr_mstatus_i = 32'h0;
    exc_vld_i = 1'b1; exc_cause_i = 4'd4; ex_pc_i = 32'h400; exc_tval_i = 32'h88;
    #1;
    chk_out("post_n", 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    exc_vld_i = 1'b0;
    chk_out("post_mepc", 1'b1, 12'h341, 32'h400, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("post_mcause", 1'b1, 12'h342, 32'h4, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("post_mtval", 1'b1, 12'h343, 32'h88, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("post_mstatus", 1'b1, 12'h300, 32'h0000_1800, 1'b1, 1'b0, 32'h0);
    tick();
    chk_out("post_jump", 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 32'h900);
    tick();
    chk_out("post_done", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
